glyph_scheduler: RTL and testbench
==================================

# glyph_scheduler

Sequences the 64×8 glyph ROM (4 glyphs × 16 rows) for the VGA text path. Tracks the pixel position inside each 8×16 character cell. Issues one ROM row fetch per cell, ahead of need, and serialises the returned 8-bit row into a 1-bit pixel stream for the colour stage. Sits between the sync generator, the text buffer and the ROM.

## Interface
- `CELL_COLS`, default 80: cells per active line; sets the range of `cellCol`.
- `clk`  in  1  pixel-domain clock.
- `reset`  in  1  synchronous, active-high reset.
- `pixelEn`  in  1  pixel-rate strobe; all counting/shifting happens only on cycles with `pixelEn=1`.
- `lineStart`  in  1  one-clock pulse in horizontal blanking; at least 3 clocks before `activeVideo` rises.
- `frameStart`  in  1  one-clock pulse in vertical blanking.
- `activeVideo`  in  1  high during visible pixels.
- `glyphSel`  in  2  glyph index for cell `cellCol`; sampled on fetch cycles.
- `romData`  in  8  ROM row, combinational from `romAddress`, MSB = leftmost pixel.
- `romAddress`  out  6  registered; equals {glyph, row}.
- `romReadEn`  out  1  one-clock pulse per fetch.
- `cellCol`  out  7  index of the next cell to fetch.
- `pixelOut`  out  1  registered glyph pixel.
- `pixelValid`  out  1  high while `pixelOut` carries a visible pixel.

## Operation
- State machine uses states `IDLE`, `PRIME_ADDR`, `PRIME_LOAD` and `RUN`.
  - `IDLE` → `PRIME_ADDR` on `lineStart`.
    - Registers `romAddress={glyphSel,rowCnt}` with `cellCol=0`.
    - Pulses `romReadEn`.
    - Sets `cellCol←1`.
  - `PRIME_ADDR` → `PRIME_LOAD` unconditionally.
    - `shiftReg←romData`.
    - `colCnt←0`.
  - `PRIME_LOAD` → `RUN` when `activeVideo` is high on a `pixelEn`. It waits otherwise.
  - `RUN` → `IDLE` when `activeVideo` falls.
- Per-pixel behaviour in `RUN`, on each `pixelEn` with `activeVideo`:
  - `pixelOut←shiftReg[7]` and `pixelValid←1`.
  - `colCnt` increments and wraps 7→0.
  - `shiftReg` shifts left, except at `colCnt=7`, where it loads `nextRow`.
- Prefetch in `RUN`:
  - On `pixelEn` with `colCnt=5`: `romAddress←{glyphSel,rowCnt}`, `romReadEn` pulses, `cellCol` increments.
  - On `pixelEn` with `colCnt=6`: `nextRow←romData`.
- `cellCol` saturates at `CELL_COLS-1`. No fetch is issued beyond it.
- `rowCnt` (4-bit):
  - Cleared by `frameStart`.
  - Increments on every falling edge of `activeVideo`, wrapping 15→0.
- Leaving `RUN` (or during `IDLE`): `pixelOut←0`, `pixelValid←0`, `cellCol←0`.
- Boundary conditions:
  - `frameStart` and `lineStart` in the same cycle: `frameStart` clears `rowCnt` first, so the prime fetch uses row 0.
  - `activeVideo` rises while still in `IDLE` (no `lineStart` seen): the line is suppressed; `pixelValid` stays 0 until the next prime.
  - `lineStart` while in `RUN`: ignored.
  - `reset` mid-line: all outputs return to reset values on the next edge; output resumes only after the next `lineStart` prime.

## Timing
- Reset values:
  - `romAddress=0`, `romReadEn=0`, `cellCol=0`, `pixelOut=0`, `pixelValid=0`.
  - State `IDLE`; `rowCnt`, `colCnt`, `shiftReg` and `nextRow` all 0.
- Latency: pixel k of a line appears on `pixelOut` one clock after the k-th `pixelEn` inside `activeVideo`.
- ROM contract: `romData` must be valid within the clock following `romAddress` registration. The ROM is combinational, so there is one cycle of slack before capture.
- Fetch cadence: exactly one `romReadEn` per cell, issued two pixels before the cell boundary.

## Configuration
- `GLYPH_SCHED_INVERT_EN` defined:
  - Adds input `invertSel` (1 bit), sampled alongside `glyphSel`.
  - A sampled 1 XORs the captured row with 8'hFF, giving an inverse-video cell.
- Undefined: no port, no XOR; rows are passed through unchanged.

## Structure
- Shared package `glyph_pkg`:
  - `CELL_W=8`, `CELL_H=16`, `GLYPH_ADDR_W=6`.
  - State enum `glyph_state_t`.
- Sub-module `glyph_shifter`: owns `shiftReg`, `nextRow`, `colCnt`, the load/shift rule and (optionally) the invert XOR.
- The top level holds the FSM, `rowCnt`, `cellCol` and the fetch logic.

## Test plan
- Reset, then `frameStart`, `lineStart`, `glyphSel=0`:
  - Prime fetch has `romAddress=6'h00`.
  - The first 8 pixels are 0,0,0,0,1,1,0,0 (row 8'h0C).
- Sixth line after `frameStart`, `glyphSel=2'b10` on every cell:
  - Each fetch has `romAddress=6'h25`.
  - `romReadEn` pulses once per 8 pixels; `cellCol` steps 1,2,3…
- 16 lines with a constant glyph: `rowCnt` wraps, and the 17th line fetches row 0 again.
- `reset` asserted at pixel 20 of an active line: next edge gives `pixelOut=0`, `pixelValid=0`, `cellCol=0`; no output until the next `lineStart`.
- `activeVideo` with no preceding `lineStart`: `pixelValid` stays 0 for the whole line.
- `GLYPH_SCHED_INVERT_EN` defined, `invertSel=1`, glyph 0 row 0: pixels 1,1,1,1,0,0,1,1.

Source files
------------

// File: rtl/glyph_pkg.sv
// Shared constants and state type for the glyph scheduler slice.
// Optional feature macro: GLYPH_SCHED_INVERT_EN (per-cell inverse video).
package glyph_pkg;

  localparam int CELL_W       = 8;
  localparam int CELL_H       = 16;
  localparam int GLYPH_ADDR_W = 6;
  localparam int ROW_W        = $clog2(CELL_H);
  localparam int COL_W        = $clog2(CELL_W);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRIME_ADDR = 2'd1,
    PRIME_LOAD = 2'd2,
    RUN        = 2'd3
  } glyph_state_t;

endpackage

// File: rtl/glyph_shifter.sv
// Pixel serialiser: holds the current and prefetched glyph rows and the column counter.
// GLYPH_SCHED_INVERT_EN adds an invert input that XORs every captured row.
module glyph_shifter
  import glyph_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              primeLoad_i,
  input  logic              pixelStep_i,
  input  logic [CELL_W-1:0] romData_i,
`ifdef GLYPH_SCHED_INVERT_EN
  input  logic              invert_i,
`endif
  output logic [COL_W-1:0]  colCnt_o,
  output logic              pixelBit_o
);

  localparam logic [COL_W-1:0] LAST_PIX    = COL_W'(CELL_W - 1);
  localparam logic [COL_W-1:0] CAPTURE_PIX = COL_W'(CELL_W - 2);

  logic [CELL_W-1:0] shiftReg_q, shiftReg_d;
  logic [CELL_W-1:0] nextRow_q, nextRow_d;
  logic [COL_W-1:0]  colCnt_q, colCnt_d;
  logic [CELL_W-1:0] rowIn;

`ifdef GLYPH_SCHED_INVERT_EN
  assign rowIn = romData_i ^ {CELL_W{invert_i}};
`else
  assign rowIn = romData_i;
`endif

  // The last pixel of a cell swaps in the prefetched row instead of shifting.
  always_comb begin
    shiftReg_d = shiftReg_q;
    nextRow_d  = nextRow_q;
    colCnt_d   = colCnt_q;
    if (primeLoad_i) begin
      shiftReg_d = rowIn;
      colCnt_d   = '0;
    end else if (pixelStep_i) begin
      colCnt_d = colCnt_q + COL_W'(1);
      if (colCnt_q == LAST_PIX) begin
        shiftReg_d = nextRow_q;
      end else begin
        shiftReg_d = {shiftReg_q[CELL_W-2:0], 1'b0};
      end
      if (colCnt_q == CAPTURE_PIX) begin
        nextRow_d = rowIn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shiftReg_q <= '0;
      nextRow_q  <= '0;
      colCnt_q   <= '0;
    end else begin
      shiftReg_q <= shiftReg_d;
      nextRow_q  <= nextRow_d;
      colCnt_q   <= colCnt_d;
    end
  end

  assign colCnt_o   = colCnt_q;
  assign pixelBit_o = shiftReg_q[CELL_W-1];

endmodule

// File: rtl/glyph_scheduler.sv
// Glyph ROM sequencer for the VGA text path: primes one row per line, prefetches per cell.
// GLYPH_SCHED_INVERT_EN adds the invertSel input for inverse-video cells.
module glyph_scheduler
  import glyph_pkg::*;
#(
  parameter int CELL_COLS = 80
)
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    pixelEn,
  input  logic                    lineStart,
  input  logic                    frameStart,
  input  logic                    activeVideo,
  input  logic [1:0]              glyphSel,
`ifdef GLYPH_SCHED_INVERT_EN
  input  logic                    invertSel,
`endif
  input  logic [CELL_W-1:0]       romData,
  output logic [GLYPH_ADDR_W-1:0] romAddress,
  output logic                    romReadEn,
  output logic [6:0]              cellCol,
  output logic                    pixelOut,
  output logic                    pixelValid
);

  localparam logic [6:0]       LAST_COL  = 7'(CELL_COLS - 1);
  localparam logic [COL_W-1:0] FETCH_PIX = COL_W'(CELL_W - 3);

  glyph_state_t state_q, state_d;
  logic [ROW_W-1:0]        rowCnt_q, rowCnt_d, rowSel;
  logic [6:0]              cellCol_q, cellCol_d;
  logic                    fetchDone_q, fetchDone_d;
  logic [GLYPH_ADDR_W-1:0] romAddress_q, romAddress_d;
  logic                    romReadEn_q, romReadEn_d;
  logic                    pixelOut_q, pixelOut_d;
  logic                    pixelValid_q, pixelValid_d;
  logic                    activePrev_q;
  logic                    pixelStep, doFetch;
  logic [COL_W-1:0]        colCnt;
  logic                    pixelBit;
`ifdef GLYPH_SCHED_INVERT_EN
  logic                    invert_q, invert_d;
`endif

  // A frameStart coinciding with lineStart must already steer the prime fetch to row 0.
  always_comb begin
    rowSel = frameStart ? '0 : rowCnt_q;
    if (frameStart) begin
      rowCnt_d = '0;
    end else if (activePrev_q && !activeVideo) begin
      rowCnt_d = rowCnt_q + ROW_W'(1);
    end else begin
      rowCnt_d = rowCnt_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    cellCol_d    = cellCol_q;
    fetchDone_d  = fetchDone_q;
    romAddress_d = romAddress_q;
    romReadEn_d  = 1'b0;
    pixelOut_d   = pixelOut_q;
    pixelValid_d = pixelValid_q;
    doFetch      = 1'b0;
    pixelStep    = pixelEn && activeVideo && (state_q == PRIME_LOAD || state_q == RUN);
`ifdef GLYPH_SCHED_INVERT_EN
    invert_d     = invert_q;
`endif

    case (state_q)
      IDLE: begin
        pixelOut_d   = 1'b0;
        pixelValid_d = 1'b0;
        cellCol_d    = '0;
        fetchDone_d  = 1'b0;
        if (lineStart) begin
          state_d = PRIME_ADDR;
          doFetch = 1'b1;
        end
      end
      PRIME_ADDR: state_d = PRIME_LOAD;
      PRIME_LOAD: begin
        if (pixelEn && activeVideo) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!activeVideo) begin
          state_d      = IDLE;
          pixelOut_d   = 1'b0;
          pixelValid_d = 1'b0;
          cellCol_d    = '0;
          fetchDone_d  = 1'b0;
        end else if (pixelEn && colCnt == FETCH_PIX && !fetchDone_q) begin
          doFetch = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pixelStep) begin
      pixelOut_d   = pixelBit;
      pixelValid_d = 1'b1;
    end

    // cellCol_d names the cell being fetched; the last column fetches once and then holds.
    if (doFetch) begin
      romAddress_d = {glyphSel, rowSel};
      romReadEn_d  = 1'b1;
`ifdef GLYPH_SCHED_INVERT_EN
      invert_d     = invertSel;
`endif
      if (cellCol_d == LAST_COL) begin
        fetchDone_d = 1'b1;
      end else begin
        cellCol_d = cellCol_d + 7'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      rowCnt_q     <= '0;
      cellCol_q    <= '0;
      fetchDone_q  <= 1'b0;
      romAddress_q <= '0;
      romReadEn_q  <= 1'b0;
      pixelOut_q   <= 1'b0;
      pixelValid_q <= 1'b0;
      activePrev_q <= 1'b0;
`ifdef GLYPH_SCHED_INVERT_EN
      invert_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rowCnt_q     <= rowCnt_d;
      cellCol_q    <= cellCol_d;
      fetchDone_q  <= fetchDone_d;
      romAddress_q <= romAddress_d;
      romReadEn_q  <= romReadEn_d;
      pixelOut_q   <= pixelOut_d;
      pixelValid_q <= pixelValid_d;
      activePrev_q <= activeVideo;
`ifdef GLYPH_SCHED_INVERT_EN
      invert_q     <= invert_d;
`endif
    end
  end

  glyph_shifter u_shifter (
    .clk         (clk),
    .reset       (reset),
    .primeLoad_i (state_q == PRIME_ADDR),
    .pixelStep_i (pixelStep),
    .romData_i   (romData),
`ifdef GLYPH_SCHED_INVERT_EN
    .invert_i    (invert_q),
`endif
    .colCnt_o    (colCnt),
    .pixelBit_o  (pixelBit)
  );

  assign romAddress = romAddress_q;
  assign romReadEn  = romReadEn_q;
  assign cellCol    = cellCol_q;
  assign pixelOut   = pixelOut_q;
  assign pixelValid = pixelValid_q;

endmodule

// File: tb/tb_glyph_scheduler.sv
// Self-checking bench for glyph_scheduler: random pixel strobes against a cell/row pixel model.
// Define GLYPH_SCHED_INVERT_EN to also exercise the inverse-video path.
module tb_glyph_scheduler;

  localparam int NCOLS = 6;

  logic       clk = 1'b0;
  logic       reset, pixelEn, lineStart, frameStart, activeVideo;
  logic [1:0] glyphSel;
  logic [7:0] romData;
  logic [5:0] romAddress;
  logic       romReadEn;
  logic [6:0] cellCol;
  logic       pixelOut, pixelValid;

  logic [7:0] rom [64];
  logic [1:0] glyphTab [128];
`ifdef GLYPH_SCHED_INVERT_EN
  logic       invertSel;
  logic       invTab [128];
  assign invertSel = invTab[cellCol];
`endif

  int checks = 0;
  int passed = 0;
  int modelRow = 0;
  int lineRow = 0;

  logic [5:0] fetchAddr [$];
  logic [6:0] fetchCol [$];
  logic       obsPix [$];
  logic       obsValid [$];
  int         validHigh;
  logic [16:0] rstSnap;

  always #5 clk = ~clk;

  // The text buffer and ROM respond combinationally to the DUT's requests.
  assign romData  = rom[romAddress];
  assign glyphSel = glyphTab[cellCol];

  glyph_scheduler #(.CELL_COLS(NCOLS)) dut (
    .clk         (clk),
    .reset       (reset),
    .pixelEn     (pixelEn),
    .lineStart   (lineStart),
    .frameStart  (frameStart),
    .activeVideo (activeVideo),
    .glyphSel    (glyphSel),
`ifdef GLYPH_SCHED_INVERT_EN
    .invertSel   (invertSel),
`endif
    .romData     (romData),
    .romAddress  (romAddress),
    .romReadEn   (romReadEn),
    .cellCol     (cellCol),
    .pixelOut    (pixelOut),
    .pixelValid  (pixelValid)
  );

  // Pixel p of a line belongs to cell p/8; cells past the last column reuse the last row.
  function automatic logic expPix(int p, int row);
    int c;
    logic [7:0] r;
    c = p / 8;
    if (c > NCOLS - 1) c = NCOLS - 1;
    r = rom[{glyphTab[c], 4'(row)}];
`ifdef GLYPH_SCHED_INVERT_EN
    if (invTab[c]) r = ~r;
`endif
    return r[7 - (p % 8)];
  endfunction

  function automatic int expFetches(int nPix);
    int n = 1;
    for (int c = 1; c < NCOLS; c++) if (8 * c - 3 <= nPix - 1) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (romReadEn) begin
      fetchAddr.push_back(romAddress);
      fetchCol.push_back(cellCol);
    end
    if (pixelValid) validHigh++;
  endtask

  task automatic setGlyphs(input int mode, input logic [1:0] g);
    for (int i = 0; i < 128; i++) begin
      glyphTab[i] = (mode == 0) ? g : 2'($urandom_range(0, 3));
`ifdef GLYPH_SCHED_INVERT_EN
      invTab[i] = (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
`endif
    end
  endtask

  // Drives one blanking interval plus an active line, logging fetches and per-pixel outputs.
  task automatic driveLine(input int nPix, input bit withLine, input bit withFrame,
                           input int resetAt, input int pulseAt);
    int cnt = 0;
    int cyc = 0;
    bit pulsed = 0;
    fetchAddr.delete(); fetchCol.delete(); obsPix.delete(); obsValid.delete();
    validHigh = 0;
    if (withFrame) modelRow = 0;
    lineRow = modelRow;
    reset = 0; lineStart = withLine; frameStart = withFrame;
    pixelEn = 1'($urandom_range(0, 1));
    step();
    lineStart = 0; frameStart = 0;
    repeat (4) begin
      pixelEn = 1'($urandom_range(0, 1));
      step();
    end
    activeVideo = 1;
    while (cnt < nPix && cyc < 2000) begin
      pixelEn   = ($urandom_range(0, 3) != 0);
      reset     = pixelEn && (cnt == resetAt);
      lineStart = !pulsed && (cnt == pulseAt);
      if (lineStart) pulsed = 1;
      step();
      cyc++;
      if (reset) begin
        rstSnap  = {pixelOut, pixelValid, cellCol, romReadEn, romAddress, 1'b0};
        modelRow = 0;
      end
      if (pixelEn) begin
        obsPix.push_back(pixelOut);
        obsValid.push_back(pixelValid);
        cnt++;
      end
    end
    reset = 0; lineStart = 0;
    checks++;
    if (cnt < nPix) $display("[TB] FAIL line_timeout: got %0d pixels, need %0d", cnt, nPix);
    else passed++;
    activeVideo = 0; pixelEn = 1;
    step();
    modelRow = (modelRow + 1) % 16;
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset = 1; pixelEn = 0; lineStart = 0; frameStart = 0; activeVideo = 0;
    repeat (3) step();
    checks += 5;
    if (romAddress !== 6'd0) $display("[TB] FAIL reset_romAddress: got %h need 00", romAddress); else passed++;
    if (romReadEn !== 1'b0) $display("[TB] FAIL reset_romReadEn: got %b need 0", romReadEn); else passed++;
    if (cellCol !== 7'd0) $display("[TB] FAIL reset_cellCol: got %0d need 0", cellCol); else passed++;
    if (pixelOut !== 1'b0) $display("[TB] FAIL reset_pixelOut: got %b need 0", pixelOut); else passed++;
    if (pixelValid !== 1'b0) $display("[TB] FAIL reset_pixelValid: got %b need 0", pixelValid); else passed++;
    reset = 0;
    step();
  endtask

  task automatic test_first_line();
    logic [7:0] want;
    want = 8'b0000_1100;
    setGlyphs(0, 2'd0);
    driveLine(16, 1, 1, -1, -1);
    checks += 2;
    if (fetchAddr.size() < 1 || fetchAddr[0] !== 6'h00)
      $display("[TB] FAIL first_prime_addr: got %p need 00", fetchAddr);
    else passed++;
    if (fetchCol.size() < 1 || fetchCol[0] !== 7'd1)
      $display("[TB] FAIL first_prime_cellCol: got %p need 1", fetchCol);
    else passed++;
    for (int p = 0; p < 16 && p < obsPix.size(); p++) begin
      checks++;
      if (obsValid[p] !== 1'b1 || obsPix[p] !== ((p < 8) ? want[7 - p] : expPix(p, 0)))
        $display("[TB] FAIL first_pixel[%0d]: got %b/%b need %b/1", p, obsPix[p], obsValid[p],
                 (p < 8) ? want[7 - p] : expPix(p, 0));
      else passed++;
    end
  endtask

  task automatic test_sixth_line();
    setGlyphs(1, 2'd0);
    driveLine(8, 1, 1, -1, -1);
    repeat (4) driveLine(8, 1, 0, -1, -1);
    setGlyphs(0, 2'd2);
    driveLine(40, 1, 0, -1, -1);
    checks++;
    if (fetchAddr.size() != expFetches(40))
      $display("[TB] FAIL sixth_fetch_count: got %0d need %0d", fetchAddr.size(), expFetches(40));
    else passed++;
    for (int i = 0; i < fetchAddr.size(); i++) begin
      checks += 2;
      if (fetchAddr[i] !== 6'h25) $display("[TB] FAIL sixth_addr[%0d]: got %h need 25", i, fetchAddr[i]);
      else passed++;
      if (fetchCol[i] !== 7'((i + 1 < NCOLS) ? i + 1 : NCOLS - 1))
        $display("[TB] FAIL sixth_cellCol[%0d]: got %0d need %0d", i, fetchCol[i],
                 (i + 1 < NCOLS) ? i + 1 : NCOLS - 1);
      else passed++;
    end
    for (int p = 0; p < obsPix.size(); p++) begin
      checks++;
      if (obsPix[p] !== expPix(p, 5) || obsValid[p] !== 1'b1)
        $display("[TB] FAIL sixth_pixel[%0d]: got %b/%b need %b/1", p, obsPix[p], obsValid[p], expPix(p, 5));
      else passed++;
    end
  endtask

  task automatic test_row_wrap();
    setGlyphs(0, 2'd3);
    for (int l = 0; l < 17; l++) begin
      driveLine(8, 1, (l == 0), -1, -1);
      checks++;
      if (fetchAddr.size() < 1 || fetchAddr[0] !== {2'd3, 4'(l % 16)})
        $display("[TB] FAIL wrap_prime_addr[%0d]: got %p need %h", l, fetchAddr, {2'd3, 4'(l % 16)});
      else passed++;
    end
  endtask

  task automatic test_random_lines();
    for (int l = 0; l < 3; l++) begin
      setGlyphs(1, 2'd0);
      driveLine(64, 1, 0, -1, 30);
      checks++;
      if (fetchAddr.size() != expFetches(64))
        $display("[TB] FAIL rand_fetch_count[%0d]: got %0d need %0d", l, fetchAddr.size(), expFetches(64));
      else passed++;
      for (int i = 0; i < fetchAddr.size() && i < NCOLS; i++) begin
        checks++;
        if (fetchAddr[i] !== {glyphTab[i], 4'(lineRow)})
          $display("[TB] FAIL rand_addr[%0d]: got %h need %h", i, fetchAddr[i], {glyphTab[i], 4'(lineRow)});
        else passed++;
      end
      for (int p = 0; p < obsPix.size(); p++) begin
        checks++;
        if (obsPix[p] !== expPix(p, lineRow) || obsValid[p] !== 1'b1)
          $display("[TB] FAIL rand_pixel[%0d]: got %b/%b need %b/1", p, obsPix[p], obsValid[p], expPix(p, lineRow));
        else passed++;
      end
    end
  endtask

  task automatic test_suppressed();
    setGlyphs(1, 2'd0);
    driveLine(24, 0, 0, -1, -1);
    checks += 2;
    if (validHigh != 0) $display("[TB] FAIL suppressed_valid: got %0d valid cycles need 0", validHigh);
    else passed++;
    if (fetchAddr.size() != 0) $display("[TB] FAIL suppressed_fetch: got %0d fetches need 0", fetchAddr.size());
    else passed++;
  endtask

  task automatic test_reset_midline();
    setGlyphs(1, 2'd0);
    rstSnap = '1;
    driveLine(48, 1, 0, 20, -1);
    checks += 2;
    if (rstSnap !== 17'd0) $display("[TB] FAIL midreset_outputs: got %h need 0", rstSnap);
    else passed++;
    if (fetchAddr.size() != 3) $display("[TB] FAIL midreset_fetches: got %0d need 3", fetchAddr.size());
    else passed++;
    for (int p = 0; p < obsPix.size(); p++) begin
      checks++;
      if (p < 20) begin
        if (obsPix[p] !== expPix(p, lineRow) || obsValid[p] !== 1'b1)
          $display("[TB] FAIL midreset_pre[%0d]: got %b/%b need %b/1", p, obsPix[p], obsValid[p], expPix(p, lineRow));
        else passed++;
      end else begin
        if (obsPix[p] !== 1'b0 || obsValid[p] !== 1'b0)
          $display("[TB] FAIL midreset_post[%0d]: got %b/%b need 0/0", p, obsPix[p], obsValid[p]);
        else passed++;
      end
    end
    driveLine(16, 1, 0, -1, -1);
    checks++;
    if (fetchAddr.size() < 1 || fetchAddr[0] !== {glyphTab[0], 4'd1})
      $display("[TB] FAIL midreset_resume_addr: got %p need %h", fetchAddr, {glyphTab[0], 4'd1});
    else passed++;
    for (int p = 0; p < obsPix.size(); p++) begin
      checks++;
      if (obsPix[p] !== expPix(p, 1) || obsValid[p] !== 1'b1)
        $display("[TB] FAIL midreset_resume[%0d]: got %b/%b need %b/1", p, obsPix[p], obsValid[p], expPix(p, 1));
      else passed++;
    end
  endtask

`ifdef GLYPH_SCHED_INVERT_EN
  task automatic test_invert();
    logic [7:0] want;
    want = 8'b1111_0011;
    setGlyphs(0, 2'd0);
    for (int i = 0; i < 128; i++) invTab[i] = 1'b1;
    driveLine(8, 1, 1, -1, -1);
    for (int p = 0; p < 8 && p < obsPix.size(); p++) begin
      checks++;
      if (obsPix[p] !== want[7 - p] || obsValid[p] !== 1'b1)
        $display("[TB] FAIL invert_pixel[%0d]: got %b/%b need %b/1", p, obsPix[p], obsValid[p], want[7 - p]);
      else passed++;
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h0C;
    setGlyphs(0, 2'd0);
    test_reset();
    test_first_line();
    test_sixth_line();
    test_row_wrap();
    test_random_lines();
    test_suppressed();
    test_reset_midline();
`ifdef GLYPH_SCHED_INVERT_EN
    test_invert();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
